// File: rtl/rc5_scheduler.sv
// RC5 block scheduler: accepts one plaintext block at a time, runs it through an
// external RC5 cipher core, and hands the ciphertext back through a valid/ready port.
module rc5_scheduler #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iKey_ready,
    input  logic             iValid,
    output logic             oReady,
    input  logic [W-1:0]     iA,
    input  logic [W-1:0]     iB,
    output logic             oValid,
    input  logic             iReady,
    output logic [W-1:0]     oA,
    output logic [W-1:0]     oB,
    output logic             oCipher_start,
    output logic [W-1:0]     oCipher_A,
    output logic [W-1:0]     oCipher_B,
    input  logic [W-1:0]     iCipher_A,
    input  logic [W-1:0]     iCipher_B,
    input  logic             iCipher_done,
    output logic             oBusy,
    output logic             oTimeout,
    output logic [CNT_W-1:0] oBlock_count
);

    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [WD_W-1:0] r_wd;
    logic [WD_W-1:0] w_wd_inc;
    logic            w_accept;
    logic            w_done;
    logic            w_expire;
    logic            w_deliver;

    // Start and ready are decoded from the state register so that an async reset
    // drops them in the same cycle it is asserted.
    assign oReady        = (r_state == S_IDLE) && iKey_ready && rst;
    assign oCipher_start = (r_state == S_RUN) || (r_state == S_HOLD);
    assign oBusy         = (r_state != S_IDLE);

    assign w_accept  = oReady && iValid;
    assign w_done    = (r_state == S_RUN) && iCipher_done;
    assign w_wd_inc  = (r_wd == '1) ? r_wd : r_wd + 1'b1;
    assign w_expire  = (r_state == S_RUN) && !iCipher_done && (32'(w_wd_inc) >= TIMEOUT);
    assign w_deliver = (r_state == S_HOLD) && iReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_RUN;
            S_RUN: begin
                if (w_done) begin
                    w_state_next = S_HOLD;
                end else if (w_expire) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_HOLD:    if (iReady) w_state_next = S_RELEASE;
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd         <= '0;
            oCipher_A    <= '0;
            oCipher_B    <= '0;
            oA           <= '0;
            oB           <= '0;
            oValid       <= 1'b0;
            oTimeout     <= 1'b0;
            oBlock_count <= '0;
        end else begin
            if (w_accept) begin
                oCipher_A <= iA;
                oCipher_B <= iB;
                r_wd      <= '0;
                oTimeout  <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_wd <= w_wd_inc;
            end
            // Done wins over an expiring watchdog in the same cycle.
            if (w_done) begin
                oA     <= iCipher_A;
                oB     <= iCipher_B;
                oValid <= 1'b1;
            end else if (w_expire) begin
                oTimeout <= 1'b1;
            end
            if (w_deliver) begin
                oValid       <= 1'b0;
                oBlock_count <= oBlock_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rc5_scheduler.sv
// Self-checking bench for rc5_scheduler: behavioural cipher model, result scoreboard,
// a vector table for single-block runs and directed timeout/gating/reset/back-to-back sequences.
module tb_rc5_scheduler;

    localparam int unsigned W       = 32;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned CNT_W   = 16;
    localparam logic [W-1:0] KA = 32'h2A8E5E5A;
    localparam logic [W-1:0] KB = 32'h1C2D3E4F;

    logic             clk;
    logic             rst;
    logic             iKey_ready;
    logic             iValid;
    logic             oReady;
    logic [W-1:0]     iA;
    logic [W-1:0]     iB;
    logic             oValid;
    logic             iReady;
    logic [W-1:0]     oA;
    logic [W-1:0]     oB;
    logic             oCipher_start;
    logic [W-1:0]     oCipher_A;
    logic [W-1:0]     oCipher_B;
    logic [W-1:0]     iCipher_A;
    logic [W-1:0]     iCipher_B;
    logic             iCipher_done;
    logic             oBusy;
    logic             oTimeout;
    logic [CNT_W-1:0] oBlock_count;

    rc5_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .iKey_ready(iKey_ready),
        .iValid(iValid), .oReady(oReady), .iA(iA), .iB(iB),
        .oValid(oValid), .iReady(iReady), .oA(oA), .oB(oB),
        .oCipher_start(oCipher_start), .oCipher_A(oCipher_A), .oCipher_B(oCipher_B),
        .iCipher_A(iCipher_A), .iCipher_B(iCipher_B), .iCipher_done(iCipher_done),
        .oBusy(oBusy), .oTimeout(oTimeout), .oBlock_count(oBlock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher model: done after m_lat start-high cycles, outputs parked while start is held.
    int unsigned m_cnt;
    int unsigned m_lat;
    bit          m_never;
    always @(posedge clk or negedge rst) begin
        if (!rst)                m_cnt <= 0;
        else if (!oCipher_start) m_cnt <= 0;
        else if (m_cnt < 1000)   m_cnt <= m_cnt + 1;
    end
    assign iCipher_done = oCipher_start && !m_never && (m_cnt >= m_lat);
    assign iCipher_A    = iCipher_done ? (oCipher_A ^ KA) : ~oCipher_A;
    assign iCipher_B    = iCipher_done ? (oCipher_B ^ KB) : ~oCipher_B;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int unsigned  lat;
        int unsigned  rdly;
    } vec_t;

    res_t        q[$];
    res_t        m_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_count = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, expected event", name);
    endtask

    always @(negedge clk) begin
        if (rst && oValid && iReady) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h/%h, expected no result", oA, oB);
            end else begin
                m_e = q.pop_front();
                check("result", {oA, oB}, {m_e.a, m_e.b});
                exp_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
        int t = 0;
        iA = a;
        iB = b;
        iValid = 1'b1;
        while (!oReady && t < 400) begin
            tick();
            t++;
        end
        if (!oReady) bound_fail("ready_wait");
        tick();
        iValid = 1'b0;
        if (expect_res) q.push_back({a ^ KA, b ^ KB});
        check("accepted", {oBusy, oCipher_start, oTimeout, oCipher_A, oCipher_B},
              {1'b1, 1'b1, 1'b0, a, b});
    endtask

    task automatic get_result(input int unsigned rdly);
        int t = 0;
        bit stable = 1'b1;
        logic [159:0] snap;
        while (!oValid && t < 400) begin
            tick();
            t++;
        end
        if (!oValid) begin
            bound_fail("valid_wait");
            return;
        end
        snap = {oValid, oCipher_start, oA, oB, oBlock_count};
        for (int i = 0; i < int'(rdly); i++) begin
            tick();
            if ({oValid, oCipher_start, oA, oB, oBlock_count} !== snap) stable = 1'b0;
        end
        if (rdly > 0) check("hold_stable", stable, 1'b1);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("handshake_done", {oValid, oBusy, oCipher_start, oReady, oTimeout, oBlock_count},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count[CNT_W-1:0]});
        tick();
        check("back_to_idle", {oBusy, oReady, oCipher_start}, {1'b0, iKey_ready, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global time limit");
    end

    vec_t vecs[5];

    initial begin
        int          n;
        int          t;
        int          low;
        bit          ok;
        int unsigned base;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];

        vecs[0] = '{32'h00000000, 32'h00000000, 110, 0};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 5,   20};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1,   3};
        vecs[3] = '{32'h80000001, 32'h7FFFFFFE, 0,   0};
        // Done lands on the same RUN cycle the watchdog expires.
        vecs[4] = '{32'hCAFEBABE, 32'h0BADF00D, 254, 1};
        bb_a = '{32'h11111111, 32'h22222222, 32'h33333333};
        bb_b = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};

        rst = 1'b0; iKey_ready = 1'b1; iValid = 1'b0; iReady = 1'b0;
        iA = '0; iB = '0; m_lat = 110; m_never = 1'b0;
        repeat (3) tick();
        check("reset_state",
              {oReady, oCipher_start, oValid, oTimeout, oBusy, oA, oB, oCipher_A, oCipher_B, oBlock_count},
              160'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            m_lat = vecs[i].lat;
            send(vecs[i].a, vecs[i].b, 1'b1);
            get_result(vecs[i].rdly);
        end

        // Watchdog expiry with no done.
        m_never = 1'b1;
        send(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
        n = 0;
        while (oCipher_start && n < 400) begin
            n++;
            tick();
        end
        check("timeout_run_cycles", n, TIMEOUT);
        check("timeout_release", {oTimeout, oValid, oBusy, oCipher_start}, 4'b1010);
        tick();
        check("timeout_idle", {oBusy, oTimeout, oReady}, 3'b011);
        m_never = 1'b0;
        m_lat = 7;
        send(32'h01020304, 32'h05060708, 1'b1);
        get_result(0);

        // Key gating.
        iKey_ready = 1'b0;
        iA = 32'h55555555; iB = 32'h66666666; iValid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oReady || oCipher_start || oBusy) ok = 1'b0;
        end
        check("key_gated", ok, 1'b1);
        iKey_ready = 1'b1;
        #1;
        check("key_raise_ready", oReady, 1'b1);
        m_lat = 3;
        send(32'h55555555, 32'h66666666, 1'b1);
        get_result(0);

        // Reset during RUN cycle 50.
        m_lat = 200;
        send(32'h99999999, 32'h88888888, 1'b0);
        repeat (49) tick();
        check("pre_reset_run", {oCipher_start, oValid}, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_run",
              {oReady, oCipher_start, oValid, oTimeout, oBusy, oA, oB, oCipher_A, oCipher_B, oBlock_count},
              160'd0);
        exp_count = 0;
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (oValid || oBusy || oCipher_start) ok = 1'b0;
        end
        check("no_output_after_reset", ok, 1'b1);

        // Back-to-back with iValid and iReady held high.
        m_lat = 20;
        base = exp_count;
        iReady = 1'b1;
        iA = bb_a[0]; iB = bb_b[0]; iValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            low = 0;
            t = 0;
            while (!oReady && t < 400) begin
                if (!oCipher_start) low++;
                tick();
                t++;
            end
            if (!oReady) bound_fail("b2b_ready_wait");
            if (!oCipher_start) low++;
            // RELEASE plus the accepting IDLE cycle.
            if (i > 0) check("restart_gap", low, 2);
            tick();
            q.push_back({bb_a[i] ^ KA, bb_b[i] ^ KB});
            check("b2b_accept", {oCipher_start, oCipher_A, oCipher_B}, {1'b1, bb_a[i], bb_b[i]});
            if (i < 2) begin
                iA = bb_a[i+1];
                iB = bb_b[i+1];
            end else begin
                iValid = 1'b0;
            end
        end
        t = 0;
        while (oBusy && t < 400) begin
            tick();
            t++;
        end
        if (oBusy) bound_fail("b2b_idle_wait");
        iReady = 1'b0;
        tick();
        check("b2b_count", oBlock_count, CNT_W'(base + 3));
        check("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
